id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register with load-use hazard detection and bubble insertion.
//  Sits between decode and execute. Captures decoded operands and control each cycle.
//  Provides ID_EX_rs_out, ID_EX_rt_out and ID_EX_rd_out to the EX-stage forwarding logic and ALU muxes.
//  Stalls PC and IF/ID for exactly one cycle on a load-use dependence that forwarding cannot cover.
// PARAMETERS
//  DATA_W      32  operand / immediate width
//  REG_ADDR_W  5   register specifier width
//  CTRL_W      8   control bundle width; bit0 = reg_write, bit1 = mem_read, rest pass-through
//  CNT_W       16  stall counter width (used only with ID_EX_STALL_COUNT_EN)
// PORTS
//  clk                  in   1           rising-edge clock
//  rst_n                in   1           asynchronous active-low reset
//  IF_ID_rs             in   REG_ADDR_W  decoded rs
//  IF_ID_rt             in   REG_ADDR_W  decoded rt
//  IF_ID_rd             in   REG_ADDR_W  decoded destination (already reg_dst-muxed)
//  IF_ID_uses_rt        in   1           instruction reads rt as a source (R-type, beq, sw)
//  IF_ID_read_data1     in   DATA_W      register file port 1
//  IF_ID_read_data2     in   DATA_W      register file port 2
//  IF_ID_imm            in   DATA_W      sign-extended immediate
//  IF_ID_ctrl           in   CTRL_W      control bundle from the main decoder
//  flush                in   1           branch/jump taken; kill the instruction in decode
//  stall_ext            in   1           external freeze (e.g. memory not ready)
//  ID_EX_rs_out         out  REG_ADDR_W  registered rs
//  ID_EX_rt_out         out  REG_ADDR_W  registered rt
//  ID_EX_rd_out         out  REG_ADDR_W  registered destination
//  ID_EX_data1_out      out  DATA_W      registered operand A
//  ID_EX_data2_out      out  DATA_W      registered operand B
//  ID_EX_imm_out        out  DATA_W      registered immediate
//  ID_EX_ctrl_out       out  CTRL_W      registered control bundle
//  ID_EX_reg_write_out  out  1           ID_EX_ctrl_out[0]
//  ID_EX_mem_read_out   out  1           ID_EX_ctrl_out[1]
//  pc_write             out  1           0 = hold PC (combinational)
//  IF_ID_write          out  1           0 = hold IF/ID (combinational)
//  load_use_stall       out  1           1 = bubble being inserted this cycle (combinational)
//  stall_count          out  CNT_W       number of load-use bubbles inserted
// BEHAVIOUR
//  - Reset (rst_n=0, async): every registered output is 0, state = RUN, stall_count = 0.
//    Reset mid-stall returns the block to RUN immediately.
//  - hazard = ID_EX_mem_read_out & (ID_EX_rt_out != 0) & ((ID_EX_rt_out == IF_ID_rs) | (IF_ID_uses_rt & (ID_EX_rt_out == IF_ID_rt))).
//  - FSM states:
//    - RUN: hazard & ~flush & ~stall_ext -> go to BUBBLE.
//    - BUBBLE: lasts exactly 1 cycle, then RUN. Reaching BUBBLE again back-to-back is impossible because a bubble clears mem_read.
//  - Register update priority at each clock edge: flush > stall_ext > hazard > normal capture.
//    - flush: load a bubble (all ID_EX outputs 0). pc_write = 1, IF_ID_write = 1, load_use_stall = 0.
//    - stall_ext (no flush): hold all ID_EX registers. pc_write = 0, IF_ID_write = 0, load_use_stall = 0.
//    - hazard: load a bubble. pc_write = 0, IF_ID_write = 0, load_use_stall = 1.
//    - otherwise: capture all IF_ID inputs. pc_write = 1, IF_ID_write = 1.
//  - Timing: latency is 1 cycle from input to output. A load-use dependence costs exactly 1 bubble.
//    The dependent instruction is captured on the cycle after the bubble, when forwarding from MEM/WB applies.
//  - Bubble content: ctrl = 0 and rs/rt/rd = 0, so the bubble never triggers forwarding or a register write.
// CONFIGURATION
//  ID_EX_STALL_COUNT_EN defined:
//    - stall_count increments by 1 on every clock edge where load_use_stall = 1.
//    - It saturates at 2^CNT_W-1; no wrap.
//  Not defined: stall_count is tied to 0 and no counter flops are built.
// TESTING
//  1. Capture: rs=3, rt=4, rd=5, data1=0x11, ctrl=0x01 -> same values on ID_EX outputs 1 cycle later, pc_write=1.
//  2. lw $8 in ID/EX (mem_read=1, rt=8), next decode add rs=8 -> load_use_stall=1, pc_write=0;
//     next cycle ID_EX_ctrl_out=0, rd_out=0; following cycle the add is captured.
//  3. lw to $0 followed by a read of $0, and uses_rt=0 with rt match -> no stall.
//  4. flush=1 in the same cycle as a hazard -> bubble loaded, pc_write=1, stall_count unchanged.
//  5. stall_ext=1 for 3 cycles -> ID_EX outputs frozen, pc_write=0; resume on release.
//     rst_n pulled low mid-stall -> all outputs 0 asynchronously.
//  6. ID_EX_STALL_COUNT_EN with CNT_W=4: 20 load-use bubbles -> stall_count=15 (saturated).
//     Without the macro -> stall_count=0 throughout.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and single-cycle bubble insertion.
// Optional bubble counter is enabled with macro ID_EX_STALL_COUNT_EN.
module id_ex_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CTRL_W     = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_rt,
  input  logic [REG_ADDR_W-1:0] IF_ID_rd,
  input  logic                  IF_ID_uses_rt,
  input  logic [DATA_W-1:0]     IF_ID_read_data1,
  input  logic [DATA_W-1:0]     IF_ID_read_data2,
  input  logic [DATA_W-1:0]     IF_ID_imm,
  input  logic [CTRL_W-1:0]     IF_ID_ctrl,
  input  logic                  flush,
  input  logic                  stall_ext,
  output logic [REG_ADDR_W-1:0] ID_EX_rs_out,
  output logic [REG_ADDR_W-1:0] ID_EX_rt_out,
  output logic [REG_ADDR_W-1:0] ID_EX_rd_out,
  output logic [DATA_W-1:0]     ID_EX_data1_out,
  output logic [DATA_W-1:0]     ID_EX_data2_out,
  output logic [DATA_W-1:0]     ID_EX_imm_out,
  output logic [CTRL_W-1:0]     ID_EX_ctrl_out,
  output logic                  ID_EX_reg_write_out,
  output logic                  ID_EX_mem_read_out,
  output logic                  pc_write,
  output logic                  IF_ID_write,
  output logic                  load_use_stall,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int unsigned CTRL_REG_WRITE = 0;
  localparam int unsigned CTRL_MEM_READ  = 1;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic hazard;
  logic rs_hit;
  logic rt_hit;
  logic load_bubble;
  logic capture;

  // A load in EX whose target is read by the decode instruction cannot be forwarded in time.
  assign rs_hit = (ID_EX_rt_out == IF_ID_rs);
  assign rt_hit = IF_ID_uses_rt && (ID_EX_rt_out == IF_ID_rt);
  assign hazard = ID_EX_mem_read_out && (ID_EX_rt_out != '0) && (rs_hit || rt_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (hazard && !flush && !stall_ext) begin
          state_nxt = ST_BUBBLE;
        end
      end
      ST_BUBBLE: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // Priority: flush > external stall > load-use hazard > normal capture.
  always_comb begin
    pc_write       = 1'b1;
    IF_ID_write    = 1'b1;
    load_use_stall = 1'b0;
    load_bubble    = 1'b0;
    capture        = 1'b0;
    if (flush) begin
      load_bubble = 1'b1;
    end else if (stall_ext) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
    end else if (hazard && (state == ST_RUN)) begin
      pc_write       = 1'b0;
      IF_ID_write    = 1'b0;
      load_use_stall = 1'b1;
      load_bubble    = 1'b1;
    end else begin
      capture = 1'b1;
    end
  end

  // Bubble zeroes specifiers too so EX forwarding never matches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_rs_out    <= '0;
      ID_EX_rt_out    <= '0;
      ID_EX_rd_out    <= '0;
      ID_EX_data1_out <= '0;
      ID_EX_data2_out <= '0;
      ID_EX_imm_out   <= '0;
      ID_EX_ctrl_out  <= '0;
    end else if (load_bubble) begin
      ID_EX_rs_out    <= '0;
      ID_EX_rt_out    <= '0;
      ID_EX_rd_out    <= '0;
      ID_EX_data1_out <= '0;
      ID_EX_data2_out <= '0;
      ID_EX_imm_out   <= '0;
      ID_EX_ctrl_out  <= '0;
    end else if (capture) begin
      ID_EX_rs_out    <= IF_ID_rs;
      ID_EX_rt_out    <= IF_ID_rt;
      ID_EX_rd_out    <= IF_ID_rd;
      ID_EX_data1_out <= IF_ID_read_data1;
      ID_EX_data2_out <= IF_ID_read_data2;
      ID_EX_imm_out   <= IF_ID_imm;
      ID_EX_ctrl_out  <= IF_ID_ctrl;
    end
  end

  assign ID_EX_reg_write_out = ID_EX_ctrl_out[CTRL_REG_WRITE];
  assign ID_EX_mem_read_out  = ID_EX_ctrl_out[CTRL_MEM_READ];

`ifdef ID_EX_STALL_COUNT_EN
  logic [CNT_W-1:0] cnt;

  // Saturating count of inserted load-use bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load_use_stall && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign stall_count = cnt;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then random traffic against a rule-level model.
module tb_id_ex_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 8;
  localparam int unsigned NW = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs, rt, rd;
  logic          uses_rt;
  logic [DW-1:0] d1, d2, imm;
  logic [CW-1:0] ctrl;
  logic          flush, stall_ext;

  logic [AW-1:0] o_rs, o_rt, o_rd;
  logic [DW-1:0] o_d1, o_d2, o_imm;
  logic [CW-1:0] o_ctrl;
  logic          o_rw, o_mr, o_pcw, o_ifw, o_lus;
  logic [NW-1:0] o_cnt;

  // Model of the ID/EX contents as the pipeline should see them.
  logic [AW-1:0] m_rs, m_rt, m_rd;
  logic [DW-1:0] m_d1, m_d2, m_imm;
  logic [CW-1:0] m_ctrl;
  int            m_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs(rs), .IF_ID_rt(rt), .IF_ID_rd(rd), .IF_ID_uses_rt(uses_rt),
    .IF_ID_read_data1(d1), .IF_ID_read_data2(d2), .IF_ID_imm(imm), .IF_ID_ctrl(ctrl),
    .flush(flush), .stall_ext(stall_ext),
    .ID_EX_rs_out(o_rs), .ID_EX_rt_out(o_rt), .ID_EX_rd_out(o_rd),
    .ID_EX_data1_out(o_d1), .ID_EX_data2_out(o_d2), .ID_EX_imm_out(o_imm),
    .ID_EX_ctrl_out(o_ctrl), .ID_EX_reg_write_out(o_rw), .ID_EX_mem_read_out(o_mr),
    .pc_write(o_pcw), .IF_ID_write(o_ifw), .load_use_stall(o_lus), .stall_count(o_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt();
`ifdef ID_EX_STALL_COUNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  function automatic bit model_hazard();
    return m_ctrl[1] && (m_rt != 0) && ((m_rt == rs) || (uses_rt && (m_rt == rt)));
  endfunction

  task automatic model_reset();
    m_rs = '0; m_rt = '0; m_rd = '0;
    m_d1 = '0; m_d2 = '0; m_imm = '0; m_ctrl = '0; m_cnt = 0;
  endtask

  task automatic model_bubble();
    m_rs = '0; m_rt = '0; m_rd = '0;
    m_d1 = '0; m_d2 = '0; m_imm = '0; m_ctrl = '0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".rs"},    32'(o_rs),   32'(m_rs));
    check({tag, ".rt"},    32'(o_rt),   32'(m_rt));
    check({tag, ".rd"},    32'(o_rd),   32'(m_rd));
    check({tag, ".data1"}, o_d1,        m_d1);
    check({tag, ".data2"}, o_d2,        m_d2);
    check({tag, ".imm"},   o_imm,       m_imm);
    check({tag, ".ctrl"},  32'(o_ctrl), 32'(m_ctrl));
    check({tag, ".rw"},    32'(o_rw),   32'(m_ctrl[0]));
    check({tag, ".mr"},    32'(o_mr),   32'(m_ctrl[1]));
    check({tag, ".cnt"},   32'(o_cnt),  32'(exp_cnt()));
  endtask

  // One pipeline cycle: drive at negedge, check handshake, clock, check registers.
  task automatic step(input string tag, input int a_rs, input int a_rt, input int a_rd,
                      input bit a_ur, input logic [DW-1:0] a_d1, input logic [DW-1:0] a_d2,
                      input logic [DW-1:0] a_imm, input logic [CW-1:0] a_ctrl,
                      input bit a_fl, input bit a_se);
    bit hz;
    bit e_pcw, e_lus;
    @(negedge clk);
    rs = AW'(a_rs); rt = AW'(a_rt); rd = AW'(a_rd); uses_rt = a_ur;
    d1 = a_d1; d2 = a_d2; imm = a_imm; ctrl = a_ctrl;
    flush = a_fl; stall_ext = a_se;
    #1;
    hz    = model_hazard();
    e_pcw = a_fl || (!a_se && !hz);
    e_lus = !a_fl && !a_se && hz;
    check({tag, ".pc_write"},    32'(o_pcw), 32'(e_pcw));
    check({tag, ".IF_ID_write"}, 32'(o_ifw), 32'(e_pcw));
    check({tag, ".lu_stall"},    32'(o_lus), 32'(e_lus));
    @(posedge clk);
    if (a_fl) begin
      model_bubble();
    end else if (a_se) begin
      // hold
    end else if (hz) begin
      model_bubble();
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_rs = rs; m_rt = rt; m_rd = rd; m_d1 = d1; m_d2 = d2; m_imm = imm; m_ctrl = ctrl;
    end
    #1;
    check_regs(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rs = '0; rt = '0; rd = '0; uses_rt = 1'b0;
    d1 = '0; d2 = '0; imm = '0; ctrl = '0; flush = 1'b0; stall_ext = 1'b0;
    model_reset();
    #12;
    check_regs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Plain capture
    step("cap", 3, 4, 5, 1'b1, 32'h11, 32'h22, 32'h33, 8'h01, 1'b0, 1'b0);

    // Load-use on rs: one bubble, then the add is captured
    step("lw8",  1, 8, 8, 1'b0, 32'h100, 32'h0, 32'h4, 8'h03, 1'b0, 1'b0);
    step("lu_stall", 8, 9, 10, 1'b1, 32'hA, 32'hB, 32'h0, 8'h01, 1'b0, 1'b0);
    check("bubble_ctrl", 32'(o_ctrl), 32'h0);
    check("bubble_rd",   32'(o_rd),   32'h0);
    step("lu_resume", 8, 9, 10, 1'b1, 32'hA, 32'hB, 32'h0, 8'h01, 1'b0, 1'b0);
    check("resume_rs", 32'(o_rs), 32'd8);

    // Load to $0 read back, and rt match with uses_rt=0: no stall
    step("lw0",    1, 0, 0, 1'b0, 32'h5, 32'h0, 32'h8, 8'h03, 1'b0, 1'b0);
    step("rd0",    0, 0, 7, 1'b1, 32'h6, 32'h7, 32'h0, 8'h01, 1'b0, 1'b0);
    step("lw9",    2, 9, 9, 1'b0, 32'h5, 32'h0, 32'h8, 8'h03, 1'b0, 1'b0);
    step("nort",   3, 9, 7, 1'b0, 32'h6, 32'h7, 32'h1, 8'h01, 1'b0, 1'b0);
    step("lw6",    2, 6, 6, 1'b0, 32'h5, 32'h0, 32'h8, 8'h03, 1'b0, 1'b0);
    step("rt_hit", 3, 6, 7, 1'b1, 32'h6, 32'h7, 32'h1, 8'h01, 1'b0, 1'b0);
    step("rt_res", 3, 6, 7, 1'b1, 32'h6, 32'h7, 32'h1, 8'h01, 1'b0, 1'b0);

    // Flush coincident with hazard
    step("lw12",  1, 12, 12, 1'b0, 32'h9, 32'h0, 32'h0, 8'h03, 1'b0, 1'b0);
    step("flush", 12, 3, 4, 1'b1, 32'h1, 32'h2, 32'h3, 8'h05, 1'b1, 1'b0);

    // External stall holds for three cycles, then reset while frozen
    step("pre_se", 4, 5, 6, 1'b1, 32'hDEAD, 32'hBEEF, 32'h77, 8'hF1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("stall_ext", 7, 8, 9, 1'b1, 32'h1, 32'h2, 32'h3, 8'h03, 1'b0, 1'b1);
    step("se_resume", 7, 8, 9, 1'b1, 32'h1, 32'h2, 32'h3, 8'h01, 1'b0, 1'b0);
    step("lw5",  1, 5, 5, 1'b0, 32'h1, 32'h0, 32'h0, 8'h03, 1'b0, 1'b0);
    @(negedge clk);
    stall_ext = 1'b1; rs = AW'(5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    stall_ext = 1'b0;

    // Twenty load-use bubbles exercise counter saturation
    for (int i = 0; i < 20; i++) begin
      step("sat_lw",  1, 8, 8, 1'b0, 32'(i), 32'h0, 32'h0, 8'h03, 1'b0, 1'b0);
      step("sat_stl", 8, 2, 3, 1'b0, 32'h1, 32'h2, 32'h3, 8'h01, 1'b0, 1'b0);
      step("sat_cap", 8, 2, 3, 1'b0, 32'h1, 32'h2, 32'h3, 8'h01, 1'b0, 1'b0);
    end
`ifdef ID_EX_STALL_COUNT_EN
    check("sat_value", 32'(o_cnt), 32'(CNT_MAX));
`else
    check("cnt_zero", 32'(o_cnt), 32'h0);
`endif

    // Random traffic with small register indices to provoke hazards
    for (int i = 0; i < 300; i++) begin
      step("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 31)), 1'($urandom), $urandom, $urandom, $urandom,
           CW'($urandom) | ((($urandom % 2) != 0) ? CW'(2) : CW'(0)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
